// File: rtl/ddr3_mem_bist_if.sv
// Command/data bus between the memory BIST engine and the DDR3 controller user port.
// The master side (BIST) issues one-cycle rd/wr/refresh pulses; the slave side
// (controller) answers with busy and a read-data strobe.
interface ddr3_mem_bist_if #(
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 16
) ();
  logic                  mem_rd;
  logic                  mem_wr;
  logic                  mem_refresh;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_din;
  logic [DATA_WIDTH-1:0] mem_dout;
  logic                  mem_data_ready;
  logic                  mem_busy;

  modport master (
    output mem_rd, mem_wr, mem_refresh, mem_addr, mem_din,
    input  mem_dout, mem_data_ready, mem_busy
  );

  modport slave (
    input  mem_rd, mem_wr, mem_refresh, mem_addr, mem_din,
    output mem_dout, mem_data_ready, mem_busy
  );
endinterface

// File: rtl/ddr3_mem_bist.sv
// Memory built-in self-test engine for the DDR3 controller user port.
// A test writes a pattern over [base, base+length) and then reads it back,
// counting mismatches and read timeouts, while slotting refresh commands in
// on a fixed cycle schedule. The address window wraps at the top of memory.
module ddr3_mem_bist #(
  parameter int ADDR_WIDTH    = 26,
  parameter int DATA_WIDTH    = 16,
  parameter int REFRESH_COUNT = 778,
  parameter int TIMEOUT       = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] seed,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] length,
  input  logic                  stop_on_error,
  ddr3_mem_bist_if.master       mem,
  output logic                  running,
  output logic                  done,
  output logic [15:0]           error_count,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_expected,
  output logic [DATA_WIDTH-1:0] fail_actual,
  output logic                  timeout,
  output logic [23:0]           refresh_count
);

  typedef enum logic [2:0] {IDLE, W_CMD, W_WAIT, R_CMD, R_WAIT, DONE} state_t;

  // Timer saturates below 2*REFRESH_COUNT so one refresh always brings it back under the threshold.
  localparam int TMR_MAX = 2 * REFRESH_COUNT - 2;
  localparam int TMR_W   = $clog2(2 * REFRESH_COUNT + 1);
  localparam int TO_W    = $clog2(TIMEOUT + 1);

  // Galois feedback masks (right-shifting form) for maximal-length polynomials.
  function automatic logic [DATA_WIDTH-1:0] lfsr_taps();
    case (DATA_WIDTH)
      8:       return DATA_WIDTH'(64'h00000000000000B8);
      16:      return DATA_WIDTH'(64'h000000000000B400);  // x^16+x^14+x^13+x^11+1
      24:      return DATA_WIDTH'(64'h0000000000E10000);
      32:      return DATA_WIDTH'(64'h0000000080200003);
      64:      return DATA_WIDTH'(64'hD800000000000000);
      default: return {1'b1, {(DATA_WIDTH-1){1'b0}}};
    endcase
  endfunction

  localparam logic [DATA_WIDTH-1:0] TAPS = lfsr_taps();

  // An all-zero LFSR would lock up, so a zero seed starts the sequence at 1.
  function automatic logic [DATA_WIDTH-1:0] lfsr_init(input logic [DATA_WIDTH-1:0] v);
    return (v == '0) ? DATA_WIDTH'(1) : v;
  endfunction

  state_t                state_reg;
  logic [ADDR_WIDTH-1:0] offset_reg;
  logic [ADDR_WIDTH-1:0] base_reg;
  logic [ADDR_WIDTH-1:0] len_reg;
  logic [DATA_WIDTH-1:0] seed_reg;
  logic [1:0]            mode_reg;
  logic                  stop_reg;
  logic [DATA_WIDTH-1:0] lfsr_reg;
  logic [DATA_WIDTH-1:0] expected_reg;
  logic                  wait_first_reg;
  logic                  cmd_data_reg;
  logic                  data_seen_reg;
  logic [TO_W-1:0]       to_cnt_reg;
  logic [TMR_W-1:0]      tmr_reg;
  logic                  refresh_needed_reg;

  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [ADDR_WIDTH-1:0] offset_inc;
  logic [ADDR_WIDTH-1:0] walk_idx;
  logic [DATA_WIDTH-1:0] addr_lo;
  logic [DATA_WIDTH-1:0] lfsr_next;
  logic [DATA_WIDTH-1:0] pattern;
  logic [TMR_W-1:0]      tmr_inc;
  logic                  start_accept;
  logic                  refresh_issue;
  logic                  last_word;
  logic                  rd_active;
  logic                  ready_now;
  logic                  to_fire;
  logic                  mismatch;
  logic                  fail_now;
  logic                  read_ok;
  logic                  wait_exit;

  assign cur_addr   = base_reg + offset_reg;
  assign offset_inc = offset_reg + ADDR_WIDTH'(1);
  assign last_word  = (offset_inc == len_reg);
  assign walk_idx   = cur_addr % ADDR_WIDTH'(DATA_WIDTH);
  assign lfsr_next  = lfsr_reg[0] ? ((lfsr_reg >> 1) ^ TAPS) : (lfsr_reg >> 1);

  generate
    if (DATA_WIDTH <= ADDR_WIDTH) begin : g_addr_narrow
      assign addr_lo = cur_addr[DATA_WIDTH-1:0];
    end else begin : g_addr_wide
      assign addr_lo = {{(DATA_WIDTH-ADDR_WIDTH){1'b0}}, cur_addr};
    end
  endgenerate

  assign start_accept  = start && ((state_reg == IDLE) || (state_reg == DONE));
  assign refresh_issue = refresh_needed_reg && ((state_reg == W_CMD) || (state_reg == R_CMD));
  assign tmr_inc       = (tmr_reg == TMR_W'(TMR_MAX)) ? tmr_reg : tmr_reg + TMR_W'(1);

  // Read completion: first strobe after a data read, or the timeout standing in for it.
  assign rd_active = (state_reg == R_WAIT) && cmd_data_reg && !data_seen_reg;
  assign ready_now = rd_active && mem.mem_data_ready;
  assign to_fire   = rd_active && !mem.mem_data_ready && (to_cnt_reg == TO_W'(TIMEOUT - 1));
  assign mismatch  = ready_now && (mem.mem_dout != expected_reg);
  assign fail_now  = mismatch || to_fire;
  assign read_ok   = (state_reg != R_WAIT) || !cmd_data_reg || data_seen_reg || ready_now || to_fire;
  assign wait_exit = !wait_first_reg && !mem.mem_busy && read_ok;

  // Data pattern for the word at the current offset.
  always_comb begin
    pattern = seed_reg;
    case (mode_reg)
      2'd0:    pattern = addr_lo ^ seed_reg;
      2'd1:    pattern = lfsr_reg;
      2'd2:    pattern = DATA_WIDTH'(1) << walk_idx;
      default: pattern = seed_reg;
    endcase
  end

  // Refresh interval timer; only advances while a test is running.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmr_reg            <= '0;
      refresh_needed_reg <= 1'b0;
    end else if (start_accept) begin
      tmr_reg            <= '0;
      refresh_needed_reg <= 1'b0;
    end else if (running) begin
      if (refresh_issue) begin
        tmr_reg            <= tmr_inc - TMR_W'(REFRESH_COUNT);
        refresh_needed_reg <= 1'b0;
      end else begin
        tmr_reg <= tmr_inc;
        if (tmr_reg == TMR_W'(REFRESH_COUNT)) begin
          refresh_needed_reg <= 1'b1;
        end
      end
    end
  end

  // Test sequencer: write pass, verify pass, status capture and command outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      offset_reg      <= '0;
      base_reg        <= '0;
      len_reg         <= '0;
      seed_reg        <= '0;
      mode_reg        <= '0;
      stop_reg        <= 1'b0;
      lfsr_reg        <= '0;
      expected_reg    <= '0;
      wait_first_reg  <= 1'b0;
      cmd_data_reg    <= 1'b0;
      data_seen_reg   <= 1'b0;
      to_cnt_reg      <= '0;
      mem.mem_rd      <= 1'b0;
      mem.mem_wr      <= 1'b0;
      mem.mem_refresh <= 1'b0;
      mem.mem_addr    <= '0;
      mem.mem_din     <= '0;
      running         <= 1'b0;
      done            <= 1'b0;
      error_count     <= '0;
      fail_addr       <= '0;
      fail_expected   <= '0;
      fail_actual     <= '0;
      timeout         <= 1'b0;
      refresh_count   <= '0;
    end else begin
      mem.mem_rd      <= 1'b0;
      mem.mem_wr      <= 1'b0;
      mem.mem_refresh <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            mode_reg      <= mode;
            seed_reg      <= seed;
            base_reg      <= base_addr;
            len_reg       <= length;
            stop_reg      <= stop_on_error;
            offset_reg    <= '0;
            lfsr_reg      <= lfsr_init(seed);
            error_count   <= '0;
            fail_addr     <= '0;
            fail_expected <= '0;
            fail_actual   <= '0;
            timeout       <= 1'b0;
            refresh_count <= '0;
            if (length == '0) begin
              state_reg <= DONE;
              running   <= 1'b0;
              done      <= 1'b1;
            end else begin
              state_reg <= W_CMD;
              running   <= 1'b1;
              done      <= 1'b0;
            end
          end
        end
        W_CMD, R_CMD: begin
          wait_first_reg <= 1'b1;
          data_seen_reg  <= 1'b0;
          to_cnt_reg     <= '0;
          if (refresh_needed_reg) begin
            mem.mem_refresh <= 1'b1;
            refresh_count   <= refresh_count + 24'd1;
            cmd_data_reg    <= 1'b0;
          end else begin
            cmd_data_reg <= 1'b1;
            mem.mem_addr <= cur_addr;
            lfsr_reg     <= lfsr_next;
            if (state_reg == W_CMD) begin
              mem.mem_wr  <= 1'b1;
              mem.mem_din <= pattern;
            end else begin
              mem.mem_rd   <= 1'b1;
              expected_reg <= pattern;
            end
          end
          state_reg <= (state_reg == W_CMD) ? W_WAIT : R_WAIT;
        end
        W_WAIT, R_WAIT: begin
          wait_first_reg <= 1'b0;
          if (rd_active) begin
            if (ready_now || to_fire) begin
              data_seen_reg <= 1'b1;
            end else begin
              to_cnt_reg <= to_cnt_reg + TO_W'(1);
            end
            if (to_fire) begin
              timeout <= 1'b1;
            end
            if (fail_now) begin
              if (error_count != 16'hFFFF) begin
                error_count <= error_count + 16'd1;
              end
              if (error_count == 16'd0) begin
                fail_addr     <= mem.mem_addr;
                fail_expected <= expected_reg;
                fail_actual   <= to_fire ? '0 : mem.mem_dout;
              end
            end
          end
          if (mismatch && stop_reg) begin
            state_reg <= DONE;
            running   <= 1'b0;
            done      <= 1'b1;
          end else if (wait_exit) begin
            if (!cmd_data_reg) begin
              state_reg <= (state_reg == W_WAIT) ? W_CMD : R_CMD;
            end else if (!last_word) begin
              offset_reg <= offset_inc;
              state_reg  <= (state_reg == W_WAIT) ? W_CMD : R_CMD;
            end else if (state_reg == W_WAIT) begin
              offset_reg <= '0;
              lfsr_reg   <= lfsr_init(seed_reg);
              state_reg  <= R_CMD;
            end else begin
              state_reg <= DONE;
              running   <= 1'b0;
              done      <= 1'b1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr3_mem_bist.sv
// Self-checking bench for ddr3_mem_bist: a behavioural controller model answers
// the command bus; expected writes/reads are queued at start and popped as the
// engine issues commands.
module tb_ddr3_mem_bist;

  localparam int AW = 26;
  localparam int DW = 16;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } txn_t;

  logic          clk;
  logic          rst;
  logic          start;
  logic [1:0]    mode;
  logic [DW-1:0] seed;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] length;
  logic          stop_on_error;
  logic          running;
  logic          done;
  logic [15:0]   error_count;
  logic [AW-1:0] fail_addr;
  logic [DW-1:0] fail_expected;
  logic [DW-1:0] fail_actual;
  logic          timeout;
  logic [23:0]   refresh_count;

  ddr3_mem_bist_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ddr3_mem_bist #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REFRESH_COUNT(20), .TIMEOUT(10)
  ) dut (
    .clk(clk), .reset(rst), .start(start), .mode(mode), .seed(seed),
    .base_addr(base_addr), .length(length), .stop_on_error(stop_on_error),
    .mem(bus.master), .running(running), .done(done), .error_count(error_count),
    .fail_addr(fail_addr), .fail_expected(fail_expected), .fail_actual(fail_actual),
    .timeout(timeout), .refresh_count(refresh_count)
  );

  int total = 0;
  int bad = 0;
  int ref_seen = 0;
  txn_t wr_q[$];
  logic [AW-1:0] rd_q[$];

  // controller model knobs
  int busy_len = 2;
  int rd_lat = 2;
  int corrupt_addr = -1;
  int withhold_addr = -1;
  logic [DW-1:0] mem_model [int];
  int busy_left = 0;
  int rd_left = 0;
  int rd_addr = 0;
  bit rd_pend = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural DDR3 controller: busy after each command, read data after a latency.
  always @(negedge clk) begin
    if (rst) begin
      busy_left = 0;
      rd_pend = 0;
      bus.mem_busy = 1'b0;
      bus.mem_data_ready = 1'b0;
      bus.mem_dout = '0;
    end else begin
      bus.mem_data_ready = 1'b0;
      if (busy_left > 0) busy_left--;
      if (rd_pend) begin
        if (rd_left == 0) begin
          bus.mem_data_ready = 1'b1;
          bus.mem_dout = (mem_model.exists(rd_addr) ? mem_model[rd_addr] : 16'h0)
                         ^ ((rd_addr == corrupt_addr) ? 16'h0001 : 16'h0000);
          rd_pend = 0;
        end else begin
          rd_left--;
        end
      end
      if (bus.mem_wr || bus.mem_rd || bus.mem_refresh) begin
        busy_left = busy_len;
        if (bus.mem_wr) mem_model[int'(bus.mem_addr)] = bus.mem_din;
        if (bus.mem_rd && int'(bus.mem_addr) != withhold_addr) begin
          rd_pend = 1;
          rd_left = rd_lat;
          rd_addr = int'(bus.mem_addr);
        end
      end
      bus.mem_busy = (busy_left > 0);
    end
  end

  function automatic logic [DW-1:0] lfsr_step(input logic [DW-1:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic logic [DW-1:0] exp_pattern(input logic [1:0] m, input logic [DW-1:0] s,
                                                input logic [AW-1:0] a, input logic [DW-1:0] l);
    case (m)
      2'd0:    return a[DW-1:0] ^ s;
      2'd1:    return l;
      2'd2:    return 16'h0001 << a[3:0];
      default: return s;
    endcase
  endfunction

  task automatic load_expected(input logic [1:0] m, input logic [DW-1:0] s, input logic [AW-1:0] b,
                               input int len, input int n_reads);
    logic [DW-1:0] l;
    txn_t t;
    wr_q.delete();
    rd_q.delete();
    l = (s == 16'h0) ? 16'h0001 : s;
    for (int i = 0; i < len; i++) begin
      t.addr = b + AW'(i);
      t.data = exp_pattern(m, s, t.addr, l);
      wr_q.push_back(t);
      l = lfsr_step(l);
    end
    for (int i = 0; i < n_reads; i++) rd_q.push_back(b + AW'(i));
  endtask

  task automatic pulse_start(input logic [1:0] m, input logic [DW-1:0] s, input logic [AW-1:0] b,
                             input int len, input bit stop);
    @(negedge clk);
    mode = m; seed = s; base_addr = b; length = AW'(len); stop_on_error = stop; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ref_seen = 0;
  endtask

  // Watch the command bus, popping the scoreboard on every command.
  task automatic watch(input int max_cycles, input bit until_done, input int stray);
    int n;
    int pulses;
    txn_t t;
    logic [AW-1:0] ra;
    n = 0;
    while (n < max_cycles && !(until_done && done)) begin
      @(negedge clk);
      n++;
      pulses = int'(bus.mem_rd) + int'(bus.mem_wr) + int'(bus.mem_refresh);
      if (pulses != 0) begin
        total++;
        if (pulses > 1) begin bad++; $display("FAIL cmd_overlap: got %0d pulses want 1", pulses); end
      end
      if (bus.mem_wr) begin
        total++;
        if (wr_q.size() == 0) begin
          bad++; $display("FAIL wr_unexpected: got addr %0h want no write", bus.mem_addr);
        end else begin
          t = wr_q.pop_front();
          total += 2;
          if (bus.mem_addr !== t.addr) begin bad++; $display("FAIL wr_addr: got %0h want %0h", bus.mem_addr, t.addr); end
          if (bus.mem_din !== t.data) begin bad++; $display("FAIL wr_data@%0h: got %0h want %0h", t.addr, bus.mem_din, t.data); end
        end
      end
      if (bus.mem_rd) begin
        total += 2;
        if (wr_q.size() != 0) begin bad++; $display("FAIL rd_early: got read with %0d writes pending want 0", wr_q.size()); end
        if (rd_q.size() == 0) begin
          bad++; $display("FAIL rd_unexpected: got addr %0h want no read", bus.mem_addr);
        end else begin
          ra = rd_q.pop_front();
          if (bus.mem_addr !== ra) begin bad++; $display("FAIL rd_addr: got %0h want %0h", bus.mem_addr, ra); end
        end
      end
      if (bus.mem_refresh) ref_seen++;
      start = (stray > 0) && (n % stray == 0) && !done;
    end
    start = 1'b0;
    if (until_done) begin
      total++;
      if (done !== 1'b1) begin bad++; $display("FAIL done_budget: got done=%0b want 1 within %0d cycles", done, max_cycles); end
    end
  endtask

  task automatic check_clean_end(input string name, input int exp_errors);
    total += 5;
    if (running !== 1'b0) begin bad++; $display("FAIL %s running: got %0b want 0", name, running); end
    if (error_count !== 16'(exp_errors)) begin bad++; $display("FAIL %s error_count: got %0d want %0d", name, error_count, exp_errors); end
    if (wr_q.size() != 0) begin bad++; $display("FAIL %s writes_missing: got %0d left want 0", name, wr_q.size()); end
    if (rd_q.size() != 0) begin bad++; $display("FAIL %s reads_missing: got %0d left want 0", name, rd_q.size()); end
    if (refresh_count !== 24'(ref_seen)) begin bad++; $display("FAIL %s refresh_count: got %0d want %0d", name, refresh_count, ref_seen); end
    $display("%s: errors=%0d refreshes=%0d fail_addr=%0h", name, error_count, refresh_count, fail_addr);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total += 8;
    if (running !== 1'b0) begin bad++; $display("FAIL rst_running: got %0b want 0", running); end
    if (done !== 1'b0) begin bad++; $display("FAIL rst_done: got %0b want 0", done); end
    if (error_count !== 16'h0) begin bad++; $display("FAIL rst_errors: got %0h want 0", error_count); end
    if (timeout !== 1'b0) begin bad++; $display("FAIL rst_timeout: got %0b want 0", timeout); end
    if (refresh_count !== 24'h0) begin bad++; $display("FAIL rst_refresh_count: got %0h want 0", refresh_count); end
    if ({bus.mem_rd, bus.mem_wr, bus.mem_refresh} !== 3'b000) begin bad++; $display("FAIL rst_pulses: got %b want 000", {bus.mem_rd, bus.mem_wr, bus.mem_refresh}); end
    if (bus.mem_addr !== '0 || bus.mem_din !== '0) begin bad++; $display("FAIL rst_bus: got addr %0h din %0h want 0", bus.mem_addr, bus.mem_din); end
    if (fail_addr !== '0 || fail_expected !== '0 || fail_actual !== '0) begin bad++; $display("FAIL rst_fail_regs: got %0h/%0h/%0h want 0", fail_addr, fail_expected, fail_actual); end
    rst = 1'b0;
    $display("reset: outputs idle");
  endtask

  task automatic test_mode0_xor();
    busy_len = 2; rd_lat = 2; corrupt_addr = -1; withhold_addr = -1;
    load_expected(2'd0, 16'h003B, '0, 16, 16);
    pulse_start(2'd0, 16'h003B, '0, 16, 1'b0);
    watch(3000, 1'b1, 0);
    check_clean_end("mode0_xor", 0);
  endtask

  task automatic test_lfsr();
    load_expected(2'd1, 16'h0000, AW'(32), 8, 8);
    pulse_start(2'd1, 16'h0000, AW'(32), 8, 1'b0);
    watch(2000, 1'b1, 0);
    check_clean_end("lfsr", 0);
  endtask

  task automatic test_corrupt();
    corrupt_addr = 5;
    for (int s = 0; s < 2; s++) begin
      load_expected(2'd0, 16'h1234, '0, 10, (s == 0) ? 10 : 6);
      pulse_start(2'd0, 16'h1234, '0, 10, s[0]);
      watch(3000, 1'b1, 0);
      watch(20, 1'b0, 0);
      total += 3;
      if (fail_addr !== AW'(5)) begin bad++; $display("FAIL corrupt_addr stop=%0d: got %0h want 5", s, fail_addr); end
      if (fail_expected !== 16'h1231) begin bad++; $display("FAIL corrupt_expected stop=%0d: got %0h want 1231", s, fail_expected); end
      if (fail_actual !== 16'h1230) begin bad++; $display("FAIL corrupt_actual stop=%0d: got %0h want 1230", s, fail_actual); end
      check_clean_end((s == 0) ? "corrupt_continue" : "corrupt_stop", 1);
    end
    corrupt_addr = -1;
  endtask

  task automatic test_refresh();
    busy_len = 3; rd_lat = 2;
    load_expected(2'd2, 16'h0000, AW'(16'h0100), 200, 200);
    pulse_start(2'd2, 16'h0000, AW'(16'h0100), 200, 1'b0);
    watch(20000, 1'b1, 0);
    total++;
    if (refresh_count === 24'd0) begin bad++; $display("FAIL refresh_issued: got 0 want >0"); end
    check_clean_end("refresh", 0);
    busy_len = 2;
  endtask

  task automatic test_timeout();
    withhold_addr = 2;
    load_expected(2'd3, 16'hA5A5, '0, 6, 6);
    pulse_start(2'd3, 16'hA5A5, '0, 6, 1'b0);
    watch(3000, 1'b1, 0);
    total += 4;
    if (timeout !== 1'b1) begin bad++; $display("FAIL to_flag: got %0b want 1", timeout); end
    if (fail_actual !== 16'h0) begin bad++; $display("FAIL to_actual: got %0h want 0", fail_actual); end
    if (fail_addr !== AW'(2)) begin bad++; $display("FAIL to_addr: got %0h want 2", fail_addr); end
    if (fail_expected !== 16'hA5A5) begin bad++; $display("FAIL to_expected: got %0h want a5a5", fail_expected); end
    check_clean_end("timeout", 1);
    withhold_addr = -1;
  endtask

  task automatic test_empty();
    load_expected(2'd0, 16'h0000, AW'(7), 0, 0);
    pulse_start(2'd0, 16'h0000, AW'(7), 0, 1'b0);
    watch(20, 1'b0, 0);
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL empty_done: got %0b want 1", done); end
    check_clean_end("empty", 0);
  endtask

  task automatic test_reset_then_wrap();
    load_expected(2'd0, 16'h5555, '0, 50, 50);
    pulse_start(2'd0, 16'h5555, '0, 50, 1'b0);
    watch(15, 1'b0, 0);
    rst = 1'b1;
    #1;
    total += 2;
    if (running !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL midrst_status: got running=%0b done=%0b want 0 0", running, done); end
    if ({bus.mem_rd, bus.mem_wr, bus.mem_refresh} !== 3'b000) begin bad++; $display("FAIL midrst_pulses: got %b want 000", {bus.mem_rd, bus.mem_wr, bus.mem_refresh}); end
    wr_q.delete();
    rd_q.delete();
    watch(4, 1'b0, 0);
    rst = 1'b0;
    load_expected(2'd0, 16'h00F0, AW'(26'h3FFFFFE), 4, 4);
    pulse_start(2'd0, 16'h00F0, AW'(26'h3FFFFFE), 4, 1'b0);
    watch(3000, 1'b1, 4);
    check_clean_end("wrap_after_reset", 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = '0; seed = '0; base_addr = '0; length = '0; stop_on_error = 1'b0;
    bus.mem_busy = 1'b0; bus.mem_data_ready = 1'b0; bus.mem_dout = '0;
    test_reset();
    test_mode0_xor();
    test_lfsr();
    test_corrupt();
    test_refresh();
    test_timeout();
    test_empty();
    test_reset_then_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
